// File: rtl/mem_wb_stage.sv
// MEM/WB stage: big-endian load alignment, GPR write-port register, HI/LO pair with forwarding.
// Latency 1 cycle mem_* -> write_*; wb_stall holds, mem_stall/flush insert a bubble.
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  mem_stall,
    input  logic                  wb_stall,
    input  logic                  mem_write_en,
    input  logic [REG_ADDR_W-1:0] mem_write_reg_addr,
    input  logic [DATA_W-1:0]     mem_write_data,
    input  logic [2:0]            mem_load_op,
    input  logic [1:0]            mem_byte_off,
    input  logic                  mem_hilo_we,
    input  logic [DATA_W-1:0]     mem_hi,
    input  logic [DATA_W-1:0]     mem_lo,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] write_reg_addr,
    output logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out
);

    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] aligned_data;
    logic              misaligned;
    logic              cap_we;

    logic              wb_hilo_we;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    // Offset 0 is the most significant byte (big-endian).
    always_comb begin
        ld_byte = 8'h00;
        case (mem_byte_off)
            2'd0:    ld_byte = mem_write_data[31:24];
            2'd1:    ld_byte = mem_write_data[23:16];
            2'd2:    ld_byte = mem_write_data[15:8];
            default: ld_byte = mem_write_data[7:0];
        endcase
        ld_half = mem_byte_off[1] ? mem_write_data[15:0] : mem_write_data[31:16];
    end

    always_comb begin
        aligned_data = mem_write_data;
        misaligned   = 1'b0;
        case (mem_load_op)
            OP_LB:   aligned_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            OP_LBU:  aligned_data = {{(DATA_W-8){1'b0}}, ld_byte};
            OP_LH: begin
                aligned_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
                misaligned   = mem_byte_off[0];
            end
            OP_LHU: begin
                aligned_data = {{(DATA_W-16){1'b0}}, ld_half};
                misaligned   = mem_byte_off[0];
            end
            OP_LW:   misaligned = (mem_byte_off != 2'd0);
            default: aligned_data = mem_write_data;
        endcase
    end

    assign cap_we = mem_write_en && !misaligned && (mem_write_reg_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst || flush || (!wb_stall && mem_stall)) begin
            write_en       <= 1'b0;
            write_reg_addr <= '0;
            write_data     <= '0;
            wb_hilo_we     <= 1'b0;
            wb_hi          <= '0;
            wb_lo          <= '0;
        end else if (!wb_stall) begin
            write_en       <= cap_we;
            write_reg_addr <= mem_write_reg_addr;
            write_data     <= aligned_data;
            wb_hilo_we     <= mem_hilo_we;
            wb_hi          <= mem_hi;
            wb_lo          <= mem_lo;
        end
    end

    // Commits regardless of flush/stall: a HI/LO write already in WB always retires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (wb_hilo_we) begin
            hi_reg <= wb_hi;
            lo_reg <= wb_lo;
        end
    end

    assign hi_out = wb_hilo_we ? wb_hi : hi_reg;
    assign lo_out = wb_hilo_we ? wb_lo : lo_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: alignment table plus reset/stall/flush/HI-LO sequences.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, mem_stall, wb_stall;
    logic        mem_write_en;
    logic [4:0]  mem_write_reg_addr;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_byte_off;
    logic        mem_hilo_we;
    logic [31:0] mem_hi, mem_lo;
    logic        write_en;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_data;
    logic [31:0] hi_out, lo_out;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .mem_stall          (mem_stall),
        .wb_stall           (wb_stall),
        .mem_write_en       (mem_write_en),
        .mem_write_reg_addr (mem_write_reg_addr),
        .mem_write_data     (mem_write_data),
        .mem_load_op        (mem_load_op),
        .mem_byte_off       (mem_byte_off),
        .mem_hilo_we        (mem_hilo_we),
        .mem_hi             (mem_hi),
        .mem_lo             (mem_lo),
        .write_en           (write_en),
        .write_reg_addr     (write_reg_addr),
        .write_data         (write_data),
        .hi_out             (hi_out),
        .lo_out             (lo_out)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [2:0]  op;
        logic [1:0]  off;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        chk_data;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] data,
                         input logic [2:0] op, input logic [1:0] off,
                         input logic hwe, input logic [31:0] hi, input logic [31:0] lo);
        mem_write_en       = we;
        mem_write_reg_addr = addr;
        mem_write_data     = data;
        mem_load_op        = op;
        mem_byte_off       = off;
        mem_hilo_we        = hwe;
        mem_hi             = hi;
        mem_lo             = lo;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic e_we, input logic [4:0] e_addr,
                       input logic [31:0] e_data, input logic c_data,
                       input logic [31:0] e_hi, input logic [31:0] e_lo);
        vectors++;
        if (write_en !== e_we || write_reg_addr !== e_addr ||
            (c_data && write_data !== e_data) || hi_out !== e_hi || lo_out !== e_lo) begin
            errors++;
            $display("FAIL %s: got we=%0b addr=%0d data=%h hi=%h lo=%h, want we=%0b addr=%0d data=%h hi=%h lo=%h",
                     name, write_en, write_reg_addr, write_data, hi_out, lo_out,
                     e_we, e_addr, e_data, e_hi, e_lo);
        end
    endtask

    initial begin
        // Memory word 0x80FF7F01 across every load flavour; misaligned rows skip the data check.
        vecs.push_back('{1'b1, 5'd3, 32'h80FF7F01, 3'b001, 2'd0, 1'b1, 32'hFFFFFF80, 1'b1});
        vecs.push_back('{1'b1, 5'd3, 32'h80FF7F01, 3'b001, 2'd1, 1'b1, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{1'b1, 5'd3, 32'h80FF7F01, 3'b001, 2'd2, 1'b1, 32'h0000007F, 1'b1});
        vecs.push_back('{1'b1, 5'd3, 32'h80FF7F01, 3'b001, 2'd3, 1'b1, 32'h00000001, 1'b1});
        vecs.push_back('{1'b1, 5'd4, 32'h80FF7F01, 3'b010, 2'd0, 1'b1, 32'h00000080, 1'b1});
        vecs.push_back('{1'b1, 5'd4, 32'h80FF7F01, 3'b010, 2'd1, 1'b1, 32'h000000FF, 1'b1});
        vecs.push_back('{1'b1, 5'd6, 32'h80FF7F01, 3'b011, 2'd0, 1'b1, 32'hFFFF80FF, 1'b1});
        vecs.push_back('{1'b1, 5'd6, 32'h80FF7F01, 3'b011, 2'd2, 1'b1, 32'h00007F01, 1'b1});
        vecs.push_back('{1'b1, 5'd7, 32'h80FF7F01, 3'b100, 2'd2, 1'b1, 32'h00007F01, 1'b1});
        vecs.push_back('{1'b1, 5'd7, 32'h80FF7F01, 3'b100, 2'd0, 1'b1, 32'h000080FF, 1'b1});
        vecs.push_back('{1'b1, 5'd8, 32'h80FF7F01, 3'b101, 2'd0, 1'b1, 32'h80FF7F01, 1'b1});
        vecs.push_back('{1'b1, 5'd9, 32'h80FF7F01, 3'b110, 2'd3, 1'b1, 32'h80FF7F01, 1'b1});
        vecs.push_back('{1'b1, 5'd10, 32'h80FF7F01, 3'b011, 2'd1, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 5'd10, 32'h80FF7F01, 3'b100, 2'd3, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 5'd11, 32'h80FF7F01, 3'b101, 2'd2, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 5'd0, 32'h0000DEAD, 3'b000, 2'd0, 1'b0, 32'h0000DEAD, 1'b1});
        vecs.push_back('{1'b0, 5'd12, 32'h00C0FFEE, 3'b000, 2'd0, 1'b0, 32'h00C0FFEE, 1'b1});

        rst = 1'b0; flush = 1'b0; mem_stall = 1'b0; wb_stall = 1'b0;
        drive(1'b1, 5'd17, 32'hFFFF_FFFF, 3'b101, 2'd0, 1'b1, 32'h55, 32'h66);
        step(); chk("reset_c1", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);
        step(); chk("reset_c2", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);

        rst = 1'b1;
        drive(1'b1, 5'd5, 32'h12345678, 3'b000, 2'd0, 1'b0, 32'h0, 32'h0);
        step(); chk("first_write", 1'b1, 5'd5, 32'h12345678, 1'b1, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].op, vecs[i].off, 1'b0, 32'h0, 32'h0);
            step();
            chk($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].addr, vecs[i].exp_data,
                vecs[i].chk_data, 32'h0, 32'h0);
        end

        // wb_stall holds while the MEM side keeps changing.
        drive(1'b1, 5'd7, 32'hCAFEF00D, 3'b000, 2'd0, 1'b0, 32'h0, 32'h0);
        step(); chk("pre_stall", 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 32'h0, 32'h0);
        wb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'(20 + c), 32'h1000 + 32'(c), 3'b000, 2'd0, 1'b1, 32'h99, 32'h98);
            step(); chk($sformatf("wb_stall_hold%0d", c), 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 32'h0, 32'h0);
        end

        wb_stall = 1'b0; mem_stall = 1'b1;
        step(); chk("mem_stall_bubble", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);

        mem_stall = 1'b0;
        drive(1'b1, 5'd9, 32'hA5A5A5A5, 3'b000, 2'd0, 1'b0, 32'h0, 32'h0);
        step(); chk("pre_flush", 1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 32'h0, 32'h0);
        flush = 1'b1; wb_stall = 1'b1;
        step(); chk("flush_over_stall", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);
        flush = 1'b0; wb_stall = 1'b0;

        drive(1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b1, 32'hA, 32'hB);
        step(); chk("hilo_forward", 1'b0, 5'd0, 32'h0, 1'b1, 32'hA, 32'hB);
        drive(1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b0, 32'h77, 32'h88);
        step(); chk("hilo_committed", 1'b0, 5'd0, 32'h0, 1'b1, 32'hA, 32'hB);
        step(); chk("hilo_persist", 1'b0, 5'd0, 32'h0, 1'b1, 32'hA, 32'hB);

        drive(1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h1111, 32'h2222);
        step(); chk("hilo2_forward", 1'b0, 5'd0, 32'h0, 1'b1, 32'h1111, 32'h2222);
        flush = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b0, 32'h0, 32'h0);
        step(); chk("flush_keeps_hilo", 1'b0, 5'd0, 32'h0, 1'b1, 32'h1111, 32'h2222);
        flush = 1'b0;

        drive(1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h3333, 32'h4444);
        step(); chk("hilo3_forward", 1'b0, 5'd0, 32'h0, 1'b1, 32'h3333, 32'h4444);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 3'b000, 2'd0, 1'b0, 32'h0, 32'h0);
        step(); chk("reset_drops_hilo", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);
        rst = 1'b1;
        step(); chk("post_reset_hilo", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

The MEM/WB pipeline stage that drives the register file write port. It captures memory-stage results and aligns load data (byte/halfword/word, signed/unsigned) before registering them. It inserts bubbles on stall or flush, and owns the architectural HI/LO pair with same-cycle forwarding. Outputs connect directly to the register file's `write_en` / `write_reg_addr` / `write_data` inputs.

## Interface
- `DATA_W`, 32, datapath width
- `REG_ADDR_W`, 5, register address width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-low (0 = reset)
- `flush`  in  1  discard captured instruction; insert bubble
- `mem_stall`  in  1  MEM stage stalled this cycle
- `wb_stall`  in  1  WB stage stalled; hold stage contents
- `mem_write_en`  in  1  MEM instruction writes a GPR
- `mem_write_reg_addr`  in  REG_ADDR_W  destination GPR
- `mem_write_data`  in  DATA_W  ALU result or raw memory read word
- `mem_load_op`  in  3  000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, others = none
- `mem_byte_off`  in  2  address bits [1:0] of the load
- `mem_hilo_we`  in  1  MEM instruction writes HI/LO
- `mem_hi`, `mem_lo`  in  DATA_W  HI/LO values
- `write_en`  out  1  to register file
- `write_reg_addr`  out  REG_ADDR_W  to register file
- `write_data`  out  DATA_W  to register file
- `hi_out`, `lo_out`  out  DATA_W  forwarded HI/LO

## Operation
- **Load alignment** is combinational on the `mem_*` inputs and is captured already aligned. Byte order is big-endian: offset 0 selects bits [31:24], offset 3 selects bits [7:0].
  - lb/lbu: select the byte; sign-extend or zero-extend.
  - lh/lhu: offset 0 selects [31:16], offset 2 selects [15:0]. Offset 1 or 3 is misaligned.
  - lw: offset must be 0; any other offset is misaligned.
  - none: pass `mem_write_data` unchanged.
  - A misaligned load forces the captured `write_en` to 0. The address and data are still captured. Exceptions are raised upstream.
- `write_en` is also forced to 0 when `mem_write_reg_addr` is 0.
- **Stage register update**, priority order at each rising edge:
  1. `rst`=0: clear everything (see Timing).
  2. `flush`=1: bubble. `write_en`, `write_reg_addr`, `write_data` and the internal `wb_hilo_we`, `wb_hi`, `wb_lo` all become 0.
  3. `wb_stall`=1: hold all stage registers.
  4. `mem_stall`=1 (and `wb_stall`=0): bubble, same as flush.
  5. Otherwise: capture the aligned `mem_*` values.
- **HI/LO architectural registers** `hi_reg` / `lo_reg`:
  - Loaded from `wb_hi` / `wb_lo` at each edge where `wb_hilo_we`=1 and `rst`=1.
  - Writing during `wb_stall` is allowed; it is idempotent.
  - A flush does not cancel a HI/LO write already in WB. That write completes at the same edge.
- **Forwarding:** `hi_out` = `wb_hilo_we` ? `wb_hi` : `hi_reg`. `lo_out` is formed the same way.

## Timing
- Reset values: `write_en`=0, `write_reg_addr`=0, `write_data`=0, `wb_hilo_we`=0, `wb_hi`=`wb_lo`=0, `hi_reg`=`lo_reg`=0, therefore `hi_out`=`lo_out`=0. The first edge with `rst`=0 clears all of these.
- Reset takes priority over `flush` and both stalls. When `rst` is asserted with a HI/LO write pending in WB, `hi_reg` / `lo_reg` clear; they do not take the pending value.
- Latency from `mem_*` to `write_*`: 1 cycle. The register file performs its write at the following edge. Same-cycle write-to-read bypass is handled inside the register file, so this stage adds no bypass for GPRs.
- HI/LO: `hi_out` / `lo_out` reflect a MEM-stage HI/LO write 1 cycle after capture (forwarded). `hi_reg` / `lo_reg` hold the value from the second edge onward.
- A held (`wb_stall`) instruction keeps presenting `write_en`=1 every cycle. Repeated writes of the same value are harmless.
- With `flush` and `wb_stall` both high, flush wins.
- No combinational path exists from `mem_*` to any output except through the stage registers.

## Test plan
- **Reset:** with `rst`=0 for 2 cycles while the `mem_*` inputs are nonzero, all outputs are 0. Release reset, drive `mem_write_en`=1, addr 5, data 0x12345678, op none; the next cycle shows `write_en`=1, addr 5, data 0x12345678.
- **Load alignment:** memory word 0x80FF7F01.
  - lb, offsets 0/1/2/3 → 0xFFFFFF80, 0xFFFFFFFF, 0x0000007F, 0x00000001.
  - lbu, offset 0 → 0x00000080.
  - lh, offset 0 → 0xFFFF80FF.
  - lhu, offset 2 → 0x00007F01.
  - lw, offset 0 → 0x80FF7F01.
- **Misaligned or r0:** lh at offset 1 → `write_en`=0. lw at offset 2 → `write_en`=0. A valid write to addr 0 → `write_en`=0.
- **Stall and flush:**
  - `wb_stall`=1 for 3 cycles → outputs are held constant.
  - `mem_stall`=1, `wb_stall`=0 → the next cycle is a bubble (all zero).
  - `flush`=1 together with `wb_stall`=1 → a bubble.
- **HI/LO:** capture `hilo_we` with hi=0xA, lo=0xB. The next cycle, `hi_out`=0xA and `lo_out`=0xB via forwarding. The cycle after, `hi_reg`=0xA and `lo_reg`=0xB. Then assert `flush` while `wb_hilo_we`=1; the HI/LO values are still committed.
- **Reset during a HI/LO write:** `rst`=0 at the edge where `wb_hilo_we`=1 → `hi_out`=`lo_out`=0 afterwards.
